// File: rtl/oh_pwrctrl.sv
`default_nettype none
// ============================================================================
// Module      : oh_pwrctrl
// Description : Power-gating sequencer for one switchable domain. Ramps the
//               footer switch segments on one at a time, then optionally
//               restores retention state, releases the domain reset and
//               removes isolation. Power-down runs the reverse sequence.
//               Optional feature macro: OH_PWRCTRL_RETENTION_EN. When it is
//               defined, the RESTORE and SAVE states generate retention
//               pulses. When it is undefined, save/restore stay 0 and those
//               states are skipped.
// Ports       : clk        - single clock
//               nreset     - synchronous active-low reset
//               req        - power request level (1 = on)
//               ack        - domain fully on and usable
//               busy       - power-up/power-down sequence in progress
//               nsleep     - per-segment footer enable (1 = conducting)
//               isolate    - 1 = domain outputs clamped
//               save       - retention save pulse
//               restore    - retention restore pulse
//               dom_nreset - active-low reset to the gated domain
// Revision    : 1.0 - initial release
// ============================================================================
module oh_pwrctrl #(
    parameter int N     = 4,
    parameter int STAGE = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         req,
    output logic         ack,
    output logic         busy,
    output logic [N-1:0] nsleep,
    output logic         isolate,
    output logic         save,
    output logic         restore,
    output logic         dom_nreset
);

    // A stage length of 0 behaves like 1.
    localparam logic [7:0]    STG      = (STAGE == 0) ? 8'd1 : 8'(STAGE);
    localparam logic [7:0]    STG_LAST = STG - 8'd1;
    localparam int            SW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] SEG_LAST = SW'(N - 1);
    localparam logic [N-1:0]  SEG0     = N'(1);

    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_RAMP    = 3'd1;
    localparam logic [2:0] ST_RESTORE = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_ON      = 3'd4;
    localparam logic [2:0] ST_ISO     = 3'd5;
    localparam logic [2:0] ST_SAVE    = 3'd6;
    localparam logic [2:0] ST_RESET   = 3'd7;

    logic [2:0]    state,   state_nx;
    logic [7:0]    stg_cnt, stg_nx;
    logic [SW-1:0] seg,     seg_nx;
    logic [N-1:0]  nsleep_nx;
    logic          ack_nx, busy_nx, isolate_nx, save_nx, restore_nx, dom_nreset_nx;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= ST_OFF;
            stg_cnt    <= 8'd0;
            seg        <= '0;
            nsleep     <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            isolate    <= 1'b1;
            save       <= 1'b0;
            restore    <= 1'b0;
            dom_nreset <= 1'b0;
        end else begin
            state      <= state_nx;
            stg_cnt    <= stg_nx;
            seg        <= seg_nx;
            nsleep     <= nsleep_nx;
            ack        <= ack_nx;
            busy       <= busy_nx;
            isolate    <= isolate_nx;
            save       <= save_nx;
            restore    <= restore_nx;
            dom_nreset <= dom_nreset_nx;
        end
    end

    // Next state, ramp counters and switch enables
    always_comb begin
        state_nx  = state;
        stg_nx    = stg_cnt;
        seg_nx    = seg;
        nsleep_nx = nsleep;
        case (state)
            ST_OFF: begin
                if (req) begin
                    state_nx  = ST_RAMP;
                    stg_nx    = 8'd0;
                    seg_nx    = '0;
                    nsleep_nx = SEG0;
                end
            end
            ST_RAMP: begin
                if (!req) begin
                    // Abort: drop every segment immediately.
                    state_nx  = ST_OFF;
                    stg_nx    = 8'd0;
                    seg_nx    = '0;
                    nsleep_nx = '0;
                end else if (stg_cnt == STG_LAST) begin
                    stg_nx = 8'd0;
                    if (seg == SEG_LAST) begin
`ifdef OH_PWRCTRL_RETENTION_EN
                        state_nx = ST_RESTORE;
`else
                        state_nx = ST_RELEASE;
`endif
                    end else begin
                        // Segments turn on strictly in index order, so a
                        // shift-in of one enables exactly the next one.
                        seg_nx    = seg + 1'b1;
                        nsleep_nx = (nsleep << 1) | SEG0;
                    end
                end else begin
                    stg_nx = stg_cnt + 8'd1;
                end
            end
            ST_RESTORE: state_nx = ST_RELEASE;
            ST_RELEASE: state_nx = ST_ON;
            ST_ON: begin
                if (!req) begin
                    state_nx = ST_ISO;
                end
            end
            ST_ISO: begin
`ifdef OH_PWRCTRL_RETENTION_EN
                state_nx = ST_SAVE;
`else
                state_nx = ST_RESET;
`endif
            end
            ST_SAVE: state_nx = ST_RESET;
            ST_RESET: begin
                state_nx  = ST_OFF;
                nsleep_nx = '0;
            end
            default: begin
                state_nx  = ST_OFF;
                nsleep_nx = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        ack_nx        = (state_nx == ST_ON);
        isolate_nx    = (state_nx != ST_ON);
        busy_nx       = (state_nx != ST_ON) && (state_nx != ST_OFF);
        dom_nreset_nx = (state_nx == ST_RELEASE) || (state_nx == ST_ON) ||
                        (state_nx == ST_ISO)     || (state_nx == ST_SAVE);
`ifdef OH_PWRCTRL_RETENTION_EN
        save_nx       = (state_nx == ST_SAVE);
        restore_nx    = (state_nx == ST_RESTORE);
`else
        save_nx       = 1'b0;
        restore_nx    = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_oh_pwrctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_oh_pwrctrl
// Description : Directed self-checking bench for oh_pwrctrl. Instance u_a uses
//               N=4/STAGE=4, instance u_b uses N=2/STAGE=0. Expected timing
//               follows OH_PWRCTRL_RETENTION_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oh_pwrctrl;

`ifdef OH_PWRCTRL_RETENTION_EN
    localparam int R = 1;
`else
    localparam int R = 0;
`endif
    localparam int NA = 4;
    localparam int SA = 4;
    localparam int NB = 2;
    localparam int LA = NA * SA + 2 + R;   // ack latency of u_a

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic req_a = 1'b0;
    logic req_b = 1'b0;

    logic          ack_a, busy_a, iso_a, save_a, rest_a, dnr_a;
    logic [NA-1:0] ns_a;
    logic          ack_b, busy_b, iso_b, save_b, rest_b, dnr_b;
    logic [NB-1:0] ns_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    oh_pwrctrl #(.N(NA), .STAGE(SA)) u_a (
        .clk(clk), .nreset(nreset), .req(req_a), .ack(ack_a), .busy(busy_a),
        .nsleep(ns_a), .isolate(iso_a), .save(save_a), .restore(rest_a),
        .dom_nreset(dnr_a)
    );

    oh_pwrctrl #(.N(NB), .STAGE(0)) u_b (
        .clk(clk), .nreset(nreset), .req(req_b), .ack(ack_b), .busy(busy_b),
        .nsleep(ns_b), .isolate(iso_b), .save(save_b), .restore(rest_b),
        .dom_nreset(dnr_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs u_a outputs: {ack,busy,isolate,save,restore,dom_nreset,nsleep}
    function automatic logic [9:0] pack_a();
        return {ack_a, busy_a, iso_a, save_a, rest_a, dnr_a, ns_a};
    endfunction

    task automatic test_reset();
        nreset = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        step();
        step();
        total++;
        if (pack_a() !== 10'b0_0_1_0_0_0_0000) begin
            bad++;
            $display("FAIL reset_a: got %b want %b", pack_a(), 10'b0010000000);
        end
        total++;
        if ({ack_b, busy_b, iso_b, save_b, rest_b, dnr_b, ns_b} !== 8'b0_0_1_0_0_0_00) begin
            bad++;
            $display("FAIL reset_b: got %b want %b",
                     {ack_b, busy_b, iso_b, save_b, rest_b, dnr_b, ns_b}, 8'b00100000);
        end
        nreset = 1'b1;
        step();
    endtask

    task automatic test_powerup();
        logic [NA-1:0] exp_ns;
        logic [9:0]    exp;
        req_a = 1'b1;
        for (int c = 1; c <= LA + 1; c++) begin
            step();
            if (c <= NA * SA) exp_ns = NA'((1 << ((c - 1) / SA + 1)) - 1);
            else              exp_ns = '1;
            exp = {(c >= LA), (c < LA), (c < LA), 1'b0,
                   (R == 1 && c == NA * SA + 1), (c >= NA * SA + 1 + R), exp_ns};
            total++;
            if (pack_a() !== exp) begin
                bad++;
                $display("FAIL powerup c%0d: got %b want %b", c, pack_a(), exp);
            end
        end
    endtask

    task automatic test_powerdown();
        logic [9:0] exp;
        req_a = 1'b0;
        for (int c = 1; c <= 4 + R; c++) begin
            step();
            if (c <= 1 + R)      exp = {1'b0, 1'b1, 1'b1, (R == 1 && c == 2), 1'b0, 1'b1, 4'b1111};
            else if (c == 2 + R) exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111};
            else                 exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
            total++;
            if (pack_a() !== exp) begin
                bad++;
                $display("FAIL powerdown c%0d: got %b want %b", c, pack_a(), exp);
            end
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        req_a = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (save_a || rest_a || !iso_a) pulses++;
        end
        total++;
        if (ns_a !== 4'b0011) begin
            bad++;
            $display("FAIL abort_c6: nsleep got %b want 0011", ns_a);
        end
        req_a = 1'b0;
        for (int c = 7; c <= 9; c++) begin
            step();
            if (save_a || rest_a || !iso_a) pulses++;
            total++;
            if (pack_a() !== 10'b0010000000) begin
                bad++;
                $display("FAIL abort c%0d: got %b want 0010000000", c, pack_a());
            end
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        req_a = 1'b1;
        repeat (LA) step();
        total++;
        if (ack_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_on: ack got %b want 1", ack_a);
        end
        nreset = 1'b0;
        step();
        total++;
        if (pack_a() !== 10'b0010000000) begin
            bad++;
            $display("FAIL reset_mid: got %b want 0010000000", pack_a());
        end
        nreset = 1'b1;
        req_a  = 1'b0;
        step();
        total++;
        if (pack_a() !== 10'b0010000000) begin
            bad++;
            $display("FAIL reset_mid_after: got %b want 0010000000", pack_a());
        end
    endtask

    task automatic test_stage0();
        logic [7:0] got, exp;
        req_b = 1'b1;
        for (int c = 1; c <= 5 + R; c++) begin
            step();
            got = {ack_b, busy_b, iso_b, save_b, rest_b, dnr_b, ns_b};
            exp = {(c >= 4 + R), (c < 4 + R), (c < 4 + R), 1'b0,
                   (R == 1 && c == 3), (c >= 3 + R), (c == 1) ? 2'b01 : 2'b11};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL stage0 c%0d: got %b want %b", c, got, exp);
            end
        end
        req_b = 1'b0;
        repeat (6) step();
        total++;
        if ({ack_b, busy_b, ns_b} !== 4'b0000) begin
            bad++;
            $display("FAIL stage0_off: got %b want 0000", {ack_b, busy_b, ns_b});
        end
    endtask

    task automatic test_random();
        logic [NA-1:0] prev;
        logic [NA-1:0] rise;
        int            on_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) req_a = ~req_a;
            prev = ns_a;
            step();
            rise = ns_a & ~prev;
            if (ack_a) on_seen++;
            total++;
            if (!iso_a && (!dnr_a || ns_a !== '1)) begin
                bad++;
                $display("FAIL rand_iso i%0d: isolate=%b dom_nreset=%b nsleep=%b",
                         i, iso_a, dnr_a, ns_a);
            end
            total++;
            if (rise != '0 && ns_a !== ((prev << 1) | NA'(1))) begin
                bad++;
                $display("FAIL rand_rise i%0d: nsleep %b -> %b", i, prev, ns_a);
            end
            total++;
            if ((prev & ~ns_a) != '0 && ns_a !== '0) begin
                bad++;
                $display("FAIL rand_fall i%0d: nsleep %b -> %b", i, prev, ns_a);
            end
        end
        total++;
        if (on_seen == 0) begin
            bad++;
            $display("FAIL rand_reach_on: got 0 ON cycles want >0");
        end
        req_a = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_powerdown();
        test_abort();
        test_reset_mid();
        test_stage0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
